// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding and timing constants for the alarm responder.
package alarm_pkg;

    // FSM state encoding, also exported on the state output.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } alarm_state_t;

    // clk_1k cycles per second.
    localparam int CYC_PER_SEC  = 1000;
    // Cycles per 5 Hz beep half-period.
    localparam int CYC_PER_BEEP = 100;
    // Cycles of 500 Hz tone at the start of each ringing second.
    localparam int TONE_HALF    = 500;

endpackage

// File: rtl/alarm_responder_if.sv
// alarm_responder_if: controls and status of the alarm responder.
// All signals are plain levels sampled on clk_1k; there is no valid/ready
// handshake. Buttons are raw and may change at any time.
interface alarm_responder_if;
    logic       en;
    logic       match;
    logic       stop_btn;
    logic       snooze_btn;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [1:0] state;
    logic [1:0] snooze_cnt;

    // Controller side: drives arming, match level and buttons, watches status.
    modport master (
        output en, match, stop_btn, snooze_btn,
        input  buzzer, ringing, snoozing, state, snooze_cnt
    );

    // Responder side.
    modport slave (
        input  en, match, stop_btn, snooze_btn,
        output buzzer, ringing, snoozing, state, snooze_cnt
    );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability counter and press-pulse
// generator for one raw, asynchronous, active-high button.
module btn_debounce #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk_1k,
    input  logic cr,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_MS + 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic [CW-1:0] cnt;

    // Synchronize, then accept a new level once it has been seen for
    // DEBOUNCE_MS consecutive cycles; pulse press on an accepted rise.
    always_ff @(posedge clk_1k or negedge cr) begin
        if (!cr) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_MS - 1)) begin
                level <= sync_b;
                cnt   <= '0;
                press <= sync_b;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/alarm_responder.sv
// alarm_responder: ring/snooze state machine and buzzer drive.
// Snooze support (SNOOZE state, snooze debouncer, snooze counter) is built
// only when the macro ALARM_SNOOZE_EN is defined; otherwise snooze_btn is
// ignored and snoozing/snooze_cnt read 0.
module alarm_responder
    import alarm_pkg::*;
#(
    parameter int RING_SEC    = 60,
    parameter int SNOOZE_SEC  = 300,
    parameter int MAX_SNOOZE  = 3,
    parameter int DEBOUNCE_MS = 20
) (
    input logic              clk_1k,
    input logic              cr,
    alarm_responder_if.slave bus
);
    localparam int SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int SEC_W   = $clog2(SEC_MAX + 1);

    alarm_state_t     state;
    logic             match_d;
    logic             match_rise;
    logic [9:0]       ms_cnt;
    logic [SEC_W-1:0] sec_cnt;
    logic             buzzer_q;
    logic             stop_press;
    logic             sec_tick;
    logic             beep_on;
    logic             ring_done;

    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_stop_db (
        .clk_1k (clk_1k),
        .cr     (cr),
        .btn    (bus.stop_btn),
        .press  (stop_press)
    );

`ifdef ALARM_SNOOZE_EN
    logic       snooze_press;
    logic [1:0] snooze_q;
    logic       snooze_done;
    logic       snooze_ok;

    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_snooze_db (
        .clk_1k (clk_1k),
        .cr     (cr),
        .btn    (bus.snooze_btn),
        .press  (snooze_press)
    );

    assign snooze_done    = sec_tick && (sec_cnt == SEC_W'(SNOOZE_SEC - 1));
    assign snooze_ok      = snooze_press && (snooze_q < 2'(MAX_SNOOZE));
    assign bus.snoozing   = (state == SNOOZE);
    assign bus.snooze_cnt = snooze_q;
`else
    logic       unused_snooze_btn;
    logic [1:0] unused_max_snooze;

    assign unused_snooze_btn = bus.snooze_btn;
    assign unused_max_snooze = 2'(MAX_SNOOZE);
    assign bus.snoozing      = 1'b0;
    assign bus.snooze_cnt    = 2'd0;
`endif

    assign sec_tick  = (ms_cnt == 10'(CYC_PER_SEC - 1));
    assign beep_on   = ((ms_cnt / 10'(CYC_PER_BEEP)) % 10'd2) == 10'd1;
    assign ring_done = sec_tick && (sec_cnt == SEC_W'(RING_SEC - 1));

    assign bus.state   = state;
    assign bus.ringing = (state == RINGING);
    assign bus.buzzer  = buzzer_q;

    // Match edge detection, ms/second dividers, state transitions and the
    // registered buzzer waveform (0 whenever the next state is not RINGING).
    always_ff @(posedge clk_1k or negedge cr) begin
        if (!cr) begin
            state      <= IDLE;
            match_d    <= 1'b0;
            match_rise <= 1'b0;
            ms_cnt     <= '0;
            sec_cnt    <= '0;
            buzzer_q   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snooze_q   <= 2'd0;
`endif
        end else begin
            match_d    <= bus.match;
            match_rise <= bus.match & ~match_d;
            ms_cnt     <= sec_tick ? '0 : ms_cnt + 1'b1;
            if (sec_tick && (sec_cnt != '1)) begin
                sec_cnt <= sec_cnt + 1'b1;
            end
            buzzer_q <= 1'b0;

            if (!bus.en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        ms_cnt  <= '0;
                        sec_cnt <= '0;
                        if (match_rise) begin
                            state <= RINGING;
`ifdef ALARM_SNOOZE_EN
                            snooze_q <= 2'd0;
`endif
                        end
                    end
                    RINGING: begin
                        if (stop_press) begin
                            state <= IDLE;
`ifdef ALARM_SNOOZE_EN
                        end else if (snooze_ok) begin
                            state    <= SNOOZE;
                            ms_cnt   <= '0;
                            sec_cnt  <= '0;
                            snooze_q <= snooze_q + 2'd1;
`endif
                        end else if (ring_done) begin
                            state <= IDLE;
                        end else begin
                            buzzer_q <= (ms_cnt < 10'(TONE_HALF)) ? ~buzzer_q : beep_on;
                        end
                    end
`ifdef ALARM_SNOOZE_EN
                    SNOOZE: begin
                        if (stop_press) begin
                            state <= IDLE;
                        end else if (snooze_done) begin
                            state   <= RINGING;
                            ms_cnt  <= '0;
                            sec_cnt <= '0;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alarm_responder.sv
// tb_alarm_responder: directed self-checking bench for alarm_responder with
// RING_SEC=3, SNOOZE_SEC=2, MAX_SNOOZE=2, DEBOUNCE_MS=2.
// Snooze scenarios follow the ALARM_SNOOZE_EN build setting.
module tb_alarm_responder;
    localparam int RING_SEC    = 3;
    localparam int SNOOZE_SEC  = 2;
    localparam int MAX_SNOOZE  = 2;
    localparam int DEBOUNCE_MS = 2;

    logic clk_1k = 1'b0;
    logic cr     = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alarm_responder_if aif ();

    alarm_responder #(
        .RING_SEC    (RING_SEC),
        .SNOOZE_SEC  (SNOOZE_SEC),
        .MAX_SNOOZE  (MAX_SNOOZE),
        .DEBOUNCE_MS (DEBOUNCE_MS)
    ) dut (
        .clk_1k (clk_1k),
        .cr     (cr),
        .bus    (aif)
    );

    // Clock and watchdog.
    always #5 clk_1k = ~clk_1k;

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Driver tasks.
    task automatic tick(input int n);
        repeat (n) @(negedge clk_1k);
    endtask

    // Low then high on match; returns cycles until ringing is seen (-1 if never).
    task automatic raise_match(output int lat);
        aif.match = 1'b0;
        tick(3);
        aif.match = 1'b1;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (aif.ringing) begin
                lat = k;
                break;
            end
        end
    endtask

    // Stay in RINGING, optionally pressing snooze for 5 cycles from press_at;
    // returns cycles until ringing falls (-1 if never).
    task automatic hold_ring(input int press_at, output int len, output bit saw_snooze);
        len = -1;
        saw_snooze = 1'b0;
        for (int k = 1; k <= 4000; k++) begin
            tick(1);
            if (press_at > 0 && k == press_at) aif.snooze_btn = 1'b1;
            if (press_at > 0 && k == press_at + 5) aif.snooze_btn = 1'b0;
            if (aif.snoozing !== 1'b0 || aif.snooze_cnt !== 2'd0) saw_snooze = 1'b1;
            if (!aif.ringing) begin
                len = k;
                break;
            end
        end
        aif.snooze_btn = 1'b0;
    endtask

    // Press a button set for 5 cycles; returns cycles until ringing falls.
    task automatic press_btns(input bit stop, input bit snooze, output int lat);
        aif.stop_btn = stop;
        aif.snooze_btn = snooze;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (k == 5) begin
                aif.stop_btn = 1'b0;
                aif.snooze_btn = 1'b0;
            end
            if (!aif.ringing && lat < 0) begin
                lat = k;
                if (k >= 5) break;
            end
        end
        aif.stop_btn = 1'b0;
        aif.snooze_btn = 1'b0;
    endtask

    task automatic test_reset();
        aif.en = 1'b0; aif.match = 1'b0; aif.stop_btn = 1'b0; aif.snooze_btn = 1'b0;
        cr = 1'b0;
        tick(3);
        checks++; if (aif.buzzer !== 1'b0) begin errors++; $display("FAIL reset_buzzer got=%b exp=0", aif.buzzer); end
        checks++; if (aif.ringing !== 1'b0) begin errors++; $display("FAIL reset_ringing got=%b exp=0", aif.ringing); end
        checks++; if (aif.snoozing !== 1'b0) begin errors++; $display("FAIL reset_snoozing got=%b exp=0", aif.snoozing); end
        checks++; if (aif.state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", aif.state); end
        checks++; if (aif.snooze_cnt !== 2'd0) begin errors++; $display("FAIL reset_snooze_cnt got=%0d exp=0", aif.snooze_cnt); end
        cr = 1'b1;
        aif.en = 1'b1;
        tick(5);
        checks++; if (aif.state !== 2'd0) begin errors++; $display("FAIL idle_after_reset got=%0d exp=0", aif.state); end
    endtask

    task automatic test_match_at_release();
        int lat;
        tick(1);
        cr = 1'b0;
        aif.match = 1'b1;
        tick(2);
        cr = 1'b1;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (aif.ringing) begin lat = k; break; end
        end
        checks++; if (lat !== 2) begin errors++; $display("FAIL match_at_release latency got=%0d exp=2", lat); end
        aif.en = 1'b0;
        tick(1);
        aif.en = 1'b1;
        aif.match = 1'b0;
        tick(3);
    endtask

    task automatic test_ring_timeout();
        int lat;
        int bad;
        int first_bad;
        logic exp_b;
        int ms;
        raise_match(lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL ring_latency got=%0d exp=2", lat); end
        checks++; if (aif.buzzer !== 1'b0) begin errors++; $display("FAIL ring_entry_buzzer got=%b exp=0", aif.buzzer); end
        exp_b = 1'b0;
        bad = 0;
        first_bad = -1;
        for (int k = 1; k < 3000; k++) begin
            tick(1);
            ms = (k - 1) % 1000;
            if (ms < 500) exp_b = ~exp_b;
            else exp_b = ((ms / 100) % 2) == 1;
            if (aif.buzzer !== exp_b || aif.ringing !== 1'b1) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL buzz_pattern bad_cycles=%0d first_at=%0d exp=0", bad, first_bad); end
        tick(1);
        checks++; if (aif.ringing !== 1'b0) begin errors++; $display("FAIL ring_timeout ringing got=%b exp=0", aif.ringing); end
        checks++; if (aif.buzzer !== 1'b0) begin errors++; $display("FAIL timeout_buzzer got=%b exp=0", aif.buzzer); end
        checks++; if (aif.state !== 2'd0) begin errors++; $display("FAIL timeout_state got=%0d exp=0", aif.state); end
    endtask

    task automatic test_stop();
        int lat;
        raise_match(lat);
        tick(50);
        press_btns(1'b1, 1'b0, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL stop_latency got=%0d exp=5", lat); end
        checks++; if (aif.buzzer !== 1'b0) begin errors++; $display("FAIL stop_buzzer got=%b exp=0", aif.buzzer); end
        tick(30);
        checks++; if (aif.state !== 2'd0) begin errors++; $display("FAIL stop_no_retrigger state got=%0d exp=0", aif.state); end
        aif.match = 1'b0;
        tick(3);
    endtask

    task automatic test_snooze();
        int lat;
        int len;
        bit saw;
        raise_match(lat);
`ifdef ALARM_SNOOZE_EN
        for (int n = 1; n <= 2; n++) begin
            hold_ring(10, len, saw);
            checks++; if (len !== 15) begin errors++; $display("FAIL snooze%0d_latency got=%0d exp=15", n, len); end
            checks++; if (aif.snoozing !== 1'b1 || aif.buzzer !== 1'b0) begin errors++; $display("FAIL snooze%0d_state snoozing=%b buzzer=%b exp=1,0", n, aif.snoozing, aif.buzzer); end
            checks++; if (aif.snooze_cnt !== 2'(n)) begin errors++; $display("FAIL snooze%0d_cnt got=%0d exp=%0d", n, aif.snooze_cnt, n); end
            len = -1;
            for (int k = 1; k <= 3000; k++) begin
                tick(1);
                if (aif.ringing) begin len = k; break; end
            end
            checks++; if (len !== 2000) begin errors++; $display("FAIL snooze%0d_length got=%0d exp=2000", n, len); end
        end
        hold_ring(10, len, saw);
        checks++; if (len !== 3000) begin errors++; $display("FAIL snooze_max_ignored ring_len got=%0d exp=3000", len); end
        checks++; if (aif.snooze_cnt !== 2'd2 || aif.state !== 2'd0) begin errors++; $display("FAIL snooze_max_end cnt=%0d state=%0d exp=2,0", aif.snooze_cnt, aif.state); end
`else
        hold_ring(100, len, saw);
        checks++; if (len !== 3000) begin errors++; $display("FAIL snooze_ignored ring_len got=%0d exp=3000", len); end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL snooze_outputs_tied saw_nonzero=%b exp=0", saw); end
`endif
    endtask

    task automatic test_stop_snooze_same();
        int lat;
        raise_match(lat);
        tick(20);
        press_btns(1'b1, 1'b1, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL stop_snooze_latency got=%0d exp=5", lat); end
        tick(10);
        checks++; if (aif.state !== 2'd0 || aif.snooze_cnt !== 2'd0) begin errors++; $display("FAIL stop_snooze_end state=%0d cnt=%0d exp=0,0", aif.state, aif.snooze_cnt); end
        aif.match = 1'b0;
        tick(3);
    endtask

    task automatic test_en_drop();
        int lat;
        int len;
        bit saw;
        raise_match(lat);
`ifdef ALARM_SNOOZE_EN
        tick(10);
        hold_ring(1, len, saw);
        checks++; if (aif.snoozing !== 1'b1) begin errors++; $display("FAIL en_drop_setup snoozing got=%b exp=1", aif.snoozing); end
`endif
        tick(100);
        aif.en = 1'b0;
        tick(1);
        checks++; if (aif.state !== 2'd0) begin errors++; $display("FAIL en_drop_state got=%0d exp=0", aif.state); end
        checks++; if (aif.buzzer !== 1'b0) begin errors++; $display("FAIL en_drop_buzzer got=%b exp=0", aif.buzzer); end
        aif.match = 1'b0;
        tick(3);
        aif.match = 1'b1;
        tick(10);
        checks++; if (aif.state !== 2'd0) begin errors++; $display("FAIL en_low_match state got=%0d exp=0", aif.state); end
        aif.en = 1'b1;
        tick(10);
        checks++; if (aif.ringing !== 1'b0) begin errors++; $display("FAIL en_restore_no_edge ringing got=%b exp=0", aif.ringing); end
        aif.match = 1'b0;
        tick(3);
    endtask

    task automatic test_cr_mid_ring();
        int lat;
        int len;
        bit saw;
        raise_match(lat);
        tick(1500);
        checks++; if (aif.buzzer !== 1'b1) begin errors++; $display("FAIL pre_cr_buzzer got=%b exp=1", aif.buzzer); end
        cr = 1'b0;
        #1;
        checks++; if (aif.buzzer !== 1'b0 || aif.ringing !== 1'b0 || aif.state !== 2'd0) begin errors++; $display("FAIL cr_async buzzer=%b ringing=%b state=%0d exp=0,0,0", aif.buzzer, aif.ringing, aif.state); end
        aif.match = 1'b0;
        tick(2);
        cr = 1'b1;
        tick(3);
        raise_match(lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL post_cr_latency got=%0d exp=2", lat); end
        hold_ring(0, len, saw);
        checks++; if (len !== 3000) begin errors++; $display("FAIL post_cr_ring_len got=%0d exp=3000", len); end
        aif.match = 1'b0;
        tick(3);
    endtask

    initial begin
        test_reset();
        test_match_at_release();
        test_ring_timeout();
        test_stop();
        test_snooze();
        test_stop_snooze_same();
        test_en_drop();
        test_cr_mid_ring();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
